acc_ctrl: RTL

ACC_CTRL -- requirements
Module: acc_ctrl

---
 rtl/acc_pkg.sv | 14 +
 rtl/acc_buffer.sv | 33 +++
 rtl/acc_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared types and defaults for the accumulator result controller.
// The state enum is used by acc_ctrl; acc_buffer takes its default sizes from here.
package acc_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/acc_buffer.sv
// DEPTH x WIDTH result register file with one synchronous write port,
// one combinational read port, and every entry cleared by reset.
module acc_buffer
   import acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [PW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [PW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/acc_ctrl.sv
// Result collection controller: captures cfg_len results from the systolic array,
// then drains them in order to the consumer with a last marker and a done pulse.
module acc_ctrl
   import acc_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int LW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LW-1:0]    cfg_len,
   input  logic             abort,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   input  logic             out_ready,
   output logic             busy,
   output logic             full,
   output logic             done,
   output logic             cfg_err
);

   localparam int PW = $clog2(DEPTH);

   state_t           state;
   state_t           state_next;
   logic [LW-1:0]    len;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             done_q;
   logic             cfg_err_q;
   logic             accept;
   logic             reject;
   logic             wr_en;
   logic             rd_en;
   logic             wr_last;
   logic             rd_last;
   logic [WIDTH-1:0] rd_data;

   // Pointers stop at len-1, so the final entry is detected by comparison, not by wrap.
   assign wr_last = (LW'(wr_ptr) == len - LW'(1));
   assign rd_last = (LW'(rd_ptr) == len - LW'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Abort overrides everything, so no write, read or job acceptance happens in that cycle.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      reject     = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if ((cfg_len != '0) && (cfg_len <= LW'(DEPTH))) begin
                     accept     = 1'b1;
                     state_next = FILL;
                  end else begin
                     reject = 1'b1;
                  end
               end
            end
            FILL: begin
               if (in_valid) begin
                  wr_en = 1'b1;
                  if (wr_last) begin
                     state_next = DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  rd_en = 1'b1;
                  if (rd_last) begin
                     state_next = IDLE;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         done_q    <= rd_en && rd_last;
         cfg_err_q <= reject;
         if (accept) begin
            len    <= cfg_len;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end
         if (wr_en && !wr_last) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (rd_en && !rd_last) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   acc_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_buffer (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   // Every output is a function of registered state only; out_data is masked outside DRAIN.
   assign in_ready  = (state == FILL);
   assign out_valid = (state == DRAIN);
   assign full      = (state == DRAIN);
   assign busy      = (state != IDLE);
   assign out_data  = (state == DRAIN) ? rd_data : '0;
   assign out_last  = (state == DRAIN) && rd_last;
   assign done      = done_q;
   assign cfg_err   = cfg_err_q;

endmodule
